// File: rtl/boot_load_ctrl_if.sv
// Byte-stream and RAM write-port bundle for the UART boot loader.
// master: the controller side; slave: UART RX/TX and RAM side.
interface boot_load_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_gnt,
    output rx_ready, tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_gnt,
    input  rx_ready, tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/boot_load_ctrl.sv
// UART-driven boot sequencer: holds/releases the core and loads framed words into RAM.
// Define BOOT_CHECKSUM_EN to append a one-byte frame checksum (CSUM state).
module boot_load_ctrl #(
  parameter logic [7:0]  STP_BYTE      = 8'h55,
  parameter logic [7:0]  ON_BYTE       = 8'hAA,
  parameter logic [7:0]  LOAD_BYTE     = 8'h4C,
  parameter int unsigned MEM_SIZE      = 65536,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  boot_load_ctrl_if.master   bus,
  output logic               core_rst_n,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    StRun,
    StHold,
    StAddr,
    StLen,
    StData,
    StWrite,
`ifdef BOOT_CHECKSUM_EN
    StCsum,
`endif
    StResp
  } state_e;

  localparam state_e ResetState = HOLD_AT_RESET ? StHold : StRun;
`ifdef BOOT_CHECKSUM_EN
  localparam state_e DoneState  = StCsum;
`else
  localparam state_e DoneState  = StResp;
`endif

  state_e      state_q, state_d;
  logic        started_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        core_rst_n_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rx_ready, tx_valid, mem_req;
  logic        rx_fire;
  logic [15:0] idx_inc;
  logic [15:0] len_next;
  logic [32:0] end_addr;
  logic        in_range;

  assign rx_fire  = bus.rx_valid & rx_ready;
  assign idx_inc  = idx_q + 16'd1;
  assign len_next = {bus.rx_data, len_q[15:8]};
  // 33-bit sum so a word straddling 2^32 never wraps into range
  assign end_addr = {1'b0, addr_q} + 33'd3;
  assign in_range = end_addr < 33'(MEM_SIZE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    word_d   = word_q;
    addr_d   = addr_q;
    err_d    = err_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    mem_req  = 1'b0;

    unique case (state_q)
      StRun: begin
        rx_ready = started_q;
        if (rx_fire && bus.rx_data == STP_BYTE) state_d = StHold;
      end
      StHold: begin
        rx_ready = started_q;
        if (rx_fire) begin
          if (bus.rx_data == ON_BYTE) begin
            state_d = StRun;
          end else if (bus.rx_data == LOAD_BYTE) begin
            state_d = StAddr;
            err_d   = 1'b0;
            cnt_d   = 2'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
          end else if (bus.rx_data != STP_BYTE) begin
            err_d = 1'b1;
          end
        end
      end
      StAddr: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          base_d = {bus.rx_data, base_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q + bus.rx_data;
`endif
          if (cnt_q == 2'd3) begin
            base_d[1:0] = 2'b00;
            cnt_d       = 2'd0;
            state_d     = StLen;
          end
        end
      end
      StLen: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          len_d  = len_next;
          cnt_d  = cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q + bus.rx_data;
`endif
          if (cnt_q[0]) begin
            cnt_d   = 2'd0;
            idx_d   = 16'd0;
            state_d = (len_next == 16'd0) ? DoneState : StData;
          end
        end
      end
      StData: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          word_d = {bus.rx_data, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q + bus.rx_data;
`endif
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            addr_d  = base_q + {14'd0, idx_q, 2'b00};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // Out-of-range words are skipped in one cycle and flagged
        if (in_range) mem_req = 1'b1;
        else          err_d   = 1'b1;
        if (!in_range || bus.mem_gnt) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? DoneState : StData;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      StCsum: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          if (bus.rx_data != csum_q) err_d = 1'b1;
          state_d = StResp;
        end
      end
`endif
      StResp: begin
        tx_valid = 1'b1;
        if (bus.tx_ready) state_d = StHold;
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ResetState;
      started_q    <= 1'b0;
      cnt_q        <= 2'd0;
      base_q       <= 32'd0;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      word_q       <= 32'd0;
      addr_q       <= 32'd0;
      err_q        <= 1'b0;
      core_rst_n_q <= ~HOLD_AT_RESET;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      started_q    <= 1'b1;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      core_rst_n_q <= (state_d == StRun);
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = err_q ? 8'h15 : 8'h06;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_req;
  assign bus.mem_be    = mem_req ? 4'hF : 4'h0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;

  assign core_rst_n = core_rst_n_q;
  assign busy       = (state_q != StRun) && (state_q != StHold);
  assign err        = err_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Scoreboard bench for boot_load_ctrl: stimulus pushes expected RAM writes and TX bytes,
// monitors pop and compare on each handshake.
module tb_boot_load_ctrl;

  typedef logic [7:0] byte_q_t[$];

  logic clk;
  logic rst_n;
  logic core_rst_n;
  logic busy;
  logic err;

  boot_load_ctrl_if bus ();

  boot_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int gnt_delay;
  int tx_delay;

  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RAM grant responder: grant gnt_delay cycles after the request appears
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_gnt) begin
        bus.mem_gnt = 1'b0;
        wcnt = 0;
      end else if (bus.mem_req) begin
        if (wcnt >= gnt_delay) bus.mem_gnt = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // UART TX responder
  initial begin
    int wcnt;
    wcnt = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_ready) begin
        bus.tx_ready = 1'b0;
        wcnt = 0;
      end else if (bus.tx_valid) begin
        if (wcnt >= tx_delay) bus.tx_ready = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitors sample on the falling edge, ahead of the completing rising edge
  always @(negedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_gnt) begin
      vectors++;
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("FAIL mem_write: unexpected addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_wr.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e || bus.mem_be !== 4'hF || bus.mem_we !== 1'b1) begin
          miscompares++;
          $display("FAIL mem_write: got addr=%h data=%h be=%h, expected addr=%h data=%h be=f",
                   bus.mem_addr, bus.mem_wdata, bus.mem_be, e[63:32], e[31:0]);
        end
      end
    end
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      vectors++;
      if (exp_tx.size() == 0) begin
        miscompares++;
        $display("FAIL tx_byte: unexpected %h", bus.tx_data);
      end else begin
        logic [7:0] t;
        t = exp_tx.pop_front();
        if (bus.tx_data !== t) begin
          miscompares++;
          $display("FAIL tx_byte: got %h, expected %h", bus.tx_data, t);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!bus.rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_accept: byte %h not accepted, rx_ready=%b, expected 1", b, bus.rx_ready);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_wr.size() != 0 || exp_tx.size() != 0) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_pending", exp_wr.size() + exp_tx.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    gnt_delay    = 2;
    tx_delay     = 1;
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    #12;
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rx_ready_after_release", bus.rx_ready, 0);
    @(posedge clk);
    #1;
    check("rx_ready_hold", bus.rx_ready, 1);

    // Two-word load at 0x100, grant two cycles late
    exp_wr.push_back({32'h0000_0100, 32'h4433_2211});
    exp_wr.push_back({32'h0000_0104, 32'h8877_6655});
    exp_tx.push_back(8'h06);
    send_byte(8'h4C);
    check("busy_in_load", busy, 1);
    send_seq('{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    drain();
    check("load1_err", err, 0);
    check("load1_busy", busy, 0);
    check("load1_core_held", core_rst_n, 0);
    send_byte(8'hAA);
    check("release_core", core_rst_n, 1);

    // RUN: other bytes dropped, STP holds the core
    send_byte(8'h12);
    check("run_drop", core_rst_n, 1);
    check("run_drop_err", err, 0);
    send_byte(8'h55);
    check("stp_hold", core_rst_n, 0);

    // Unknown command in HOLD flags err
    send_byte(8'h33);
    check("unknown_cmd_err", err, 1);

    // Range boundary: 0xFFFC written, 0x10000 dropped
    gnt_delay = 0;
    exp_wr.push_back({32'h0000_FFFC, 32'hDDCC_BBAA});
    exp_tx.push_back(8'h15);
    send_byte(8'h4C);
    check("err_cleared_on_load", err, 0);
    send_seq('{8'hFC, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04});
    drain();
    check("range_err", err, 1);
    check("range_core_held", core_rst_n, 0);

    // Reset asserted while a write is pending
    gnt_delay = 20;
    send_seq('{8'h4C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04});
    begin
      int t;
      t = 0;
      while (!bus.mem_req && t < 10) begin
        @(negedge clk);
        t++;
      end
    end
    check("pending_req", bus.mem_req, 1);
    check("pending_addr", bus.mem_addr, 32'h0000_0300);
    check("pending_wdata", bus.mem_wdata, 32'h0403_0201);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", bus.mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_core", core_rst_n, 0);
    check("abort_tx_valid", bus.tx_valid, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 1;
    @(posedge clk);
    #1;

    // Frame after abort loads normally
    exp_wr.push_back({32'h0000_0200, 32'hDEAD_BEEF});
    exp_tx.push_back(8'h06);
    send_seq('{8'h4C, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE});
    drain();
    check("post_abort_err", err, 0);
    check("post_abort_core", core_rst_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
